// File: rtl/fft_frame_buf_pkg.sv
// Shared system definitions for the FIR -> frame buffer -> FFT chain.
// Holds sample/frame geometry and the FSM and bank-status encodings.
package fft_frame_buf_pkg;

  localparam int unsigned SYS_DW         = 16;
  localparam int unsigned SYS_FRAME_LEN  = 16;
  localparam int unsigned SYS_NUM_FRAMES = 64;
  localparam int unsigned FRAME_IDX_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  typedef enum logic [1:0] {
    BK_EMPTY   = 2'd0,
    BK_FILLING = 2'd1,
    BK_FULL    = 2'd2
  } bank_st_t;

  // Index width for an n-entry bank, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank: FRAME_LEN x DW registers, single write port, full parallel read-out.
// Word k sits at bits [DW*k +: DW] of o_data.
module frame_bank
  import fft_frame_buf_pkg::*;
#(
  parameter int unsigned DW        = SYS_DW,
  parameter int unsigned FRAME_LEN = SYS_FRAME_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_we,
  input  logic [idx_w(FRAME_LEN)-1:0]   i_idx,
  input  logic [DW-1:0]                 i_d,
  output logic [DW*FRAME_LEN-1:0]       o_data
);

  logic [FRAME_LEN-1:0][DW-1:0] r_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_idx] <= i_d;
    end
  end

  assign o_data = r_mem;

endmodule

// File: rtl/fft_frame_buf.sv
// Ping-pong frame buffer between a non-stallable FIR stream and the FFT.
// Fills banks A/B alternately, presents full frames in order, drops samples on overflow.
module fft_frame_buf
  import fft_frame_buf_pkg::*;
#(
  parameter int unsigned DW         = SYS_DW,
  parameter int unsigned FRAME_LEN  = SYS_FRAME_LEN,
  parameter int unsigned NUM_FRAMES = SYS_NUM_FRAMES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fir_valid,
  input  logic [DW-1:0]                 fir_d,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [DW*FRAME_LEN-1:0]       frame_d,
  output logic [FRAME_IDX_W-1:0]        frame_idx,
  output logic                          done,
  output logic                          overflow
);

  localparam int unsigned IW = idx_w(FRAME_LEN);
  localparam int unsigned FW = DW * FRAME_LEN;
  localparam logic [IW-1:0]          LAST_IDX   = IW'(FRAME_LEN - 1);
  localparam logic [FRAME_IDX_W-1:0] LAST_FRAME = FRAME_IDX_W'(NUM_FRAMES - 1);

  fsm_state_t              r_state, w_state_nxt;
  bank_st_t                r_bank_st [2];
  bank_st_t                w_bank_st_nxt [2];
  logic                    r_wr_bank, w_wr_bank_nxt;
  logic                    r_rd_bank, w_rd_bank_nxt;
  logic [IW-1:0]           r_wr_idx, w_wr_idx_nxt;
  logic [FRAME_IDX_W-1:0]  r_frame_idx, w_frame_idx_nxt;
  logic                    r_frame_valid, w_frame_valid_nxt;
  logic                    r_overflow, w_overflow_nxt;
  logic                    r_done, w_done_nxt;
  logic                    w_we_a, w_we_b;
  logic                    w_xfer, w_last_xfer, w_target_rel;
  logic [FW-1:0]           w_data_a, w_data_b;

  assign w_xfer       = r_frame_valid & frame_ready;
  assign w_last_xfer  = w_xfer & (r_frame_idx == LAST_FRAME);
  assign w_target_rel = w_xfer & (r_rd_bank == r_wr_bank);

  frame_bank #(.DW(DW), .FRAME_LEN(FRAME_LEN)) u_bank_a (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we_a),
    .i_idx  (r_wr_idx),
    .i_d    (fir_d),
    .o_data (w_data_a)
  );

  frame_bank #(.DW(DW), .FRAME_LEN(FRAME_LEN)) u_bank_b (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we_b),
    .i_idx  (r_wr_idx),
    .i_d    (fir_d),
    .o_data (w_data_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (fir_valid)   w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last_xfer) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Release is applied before the write so a sample can land in a bank freed this cycle.
  always_comb begin
    w_bank_st_nxt     = r_bank_st;
    w_wr_bank_nxt     = r_wr_bank;
    w_rd_bank_nxt     = r_rd_bank;
    w_wr_idx_nxt      = r_wr_idx;
    w_frame_idx_nxt   = r_frame_idx;
    w_overflow_nxt    = r_overflow;
    w_we_a            = 1'b0;
    w_we_b            = 1'b0;
    w_done_nxt        = (w_state_nxt == ST_DONE);

    if (w_xfer) begin
      w_bank_st_nxt[r_rd_bank] = BK_EMPTY;
      w_rd_bank_nxt            = ~r_rd_bank;
      w_frame_idx_nxt          = r_frame_idx + FRAME_IDX_W'(1);
    end

    if (w_last_xfer) begin
      w_bank_st_nxt[0] = BK_EMPTY;
      w_bank_st_nxt[1] = BK_EMPTY;
      w_wr_bank_nxt    = 1'b0;
      w_rd_bank_nxt    = 1'b0;
      w_wr_idx_nxt     = '0;
      w_frame_idx_nxt  = '0;
    end else if (fir_valid) begin
      if ((r_bank_st[r_wr_bank] == BK_FULL) && !w_target_rel) begin
        w_overflow_nxt = 1'b1;
      end else begin
        w_we_a = ~r_wr_bank;
        w_we_b = r_wr_bank;
        if (r_wr_idx == LAST_IDX) begin
          w_bank_st_nxt[r_wr_bank] = BK_FULL;
          w_wr_idx_nxt             = '0;
          w_wr_bank_nxt            = ~r_wr_bank;
        end else begin
          w_bank_st_nxt[r_wr_bank] = BK_FILLING;
          w_wr_idx_nxt             = r_wr_idx + IW'(1);
        end
      end
    end

    w_frame_valid_nxt = (w_bank_st_nxt[w_rd_bank_nxt] == BK_FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bank_st[0]  <= BK_EMPTY;
      r_bank_st[1]  <= BK_EMPTY;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_wr_idx      <= '0;
      r_frame_idx   <= '0;
      r_frame_valid <= 1'b0;
      r_overflow    <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_bank_st     <= w_bank_st_nxt;
      r_wr_bank     <= w_wr_bank_nxt;
      r_rd_bank     <= w_rd_bank_nxt;
      r_wr_idx      <= w_wr_idx_nxt;
      r_frame_idx   <= w_frame_idx_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_overflow    <= w_overflow_nxt;
      r_done        <= w_done_nxt;
    end
  end

  assign frame_valid = r_frame_valid;
  assign frame_d     = r_rd_bank ? w_data_b : w_data_a;
  assign frame_idx   = r_frame_idx;
  assign done        = r_done;
  assign overflow    = r_overflow;

endmodule
